// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with a hardware clear walk after reset.
//
// After reset the file walks registers 1..NREG-1 writing zero (one per cycle),
// then raises ready. Register 0 is hardwired to zero. Writes are accepted only
// while ready. When two write ports hit the same address, the highest port wins.
//
// Optional feature (macro REGFILE_MP_BYPASS_EN): a same-cycle write is forwarded
// to matching read lanes. Without the macro, new data appears one cycle later.
//
// Ports:
//   clk    in  1          clock, rising edge
//   rst_n  in  1          synchronous active-low reset
//   we     in  NWP        per-port write enable
//   wa     in  NWP*AW     packed write addresses (port p at [p*AW +: AW])
//   wd     in  NWP*XLEN   packed write data
//   ra     in  NRP*AW     packed read addresses
//   rd     out NRP*XLEN   packed read data, combinational from ra
//   ready  out 1          clear walk finished; writes accepted
module regfile_mp #(
  parameter  int XLEN = 32,
  parameter  int NREG = 32,
  parameter  int NRP  = 2,
  parameter  int NWP  = 2,
  localparam int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWP-1:0]      we,
  input  logic [NWP*AW-1:0]   wa,
  input  logic [NWP*XLEN-1:0] wd,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  output logic                ready
);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_cnt, w_cnt_nxt;
  logic            w_clr_we;
  logic            w_ready;

  logic [XLEN-1:0] r_mem [NREG];

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
      r_cnt   <= AW'(1);
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: the edge that clears NREG-1 also moves to READY
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr_we    = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      S_CLEAR: begin
        w_clr_we  = 1'b1;
        w_cnt_nxt = r_cnt + AW'(1);
        if (r_cnt == AW'(NREG - 1)) w_state_nxt = S_READY;
      end
      S_READY: w_ready = 1'b1;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  assign ready = w_ready;

  // Storage has no reset of its own; zeroing comes only from the clear walk.
  // Ports are visited in ascending order so the highest port's NBA lands last.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (w_clr_we) begin
        r_mem[r_cnt] <= '0;
      end else if (w_ready) begin
        for (int p = 0; p < NWP; p++) begin
          if (we[p] && (wa[p*AW +: AW] != '0))
            r_mem[wa[p*AW +: AW]] <= wd[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read lanes
  for (genvar g = 0; g < NRP; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_val;

    assign w_ra = ra[g*AW +: AW];

    always_comb begin
      w_val = r_mem[w_ra];
`ifdef REGFILE_MP_BYPASS_EN
      // Ascending scan: last match is the highest port, matching write priority
      for (int p = 0; p < NWP; p++) begin
        if (we[p] && (wa[p*AW +: AW] == w_ra))
          w_val = wd[p*XLEN +: XLEN];
      end
`endif
      if (!w_ready || (w_ra == '0)) w_val = '0;
    end

    assign rd[g*XLEN +: XLEN] = w_val;
  end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int NWP  = 2;
  localparam int AW   = 5;

  logic                clk;
  logic                rst_n;
  logic [NWP-1:0]      we;
  logic [NWP*AW-1:0]   wa;
  logic [NWP*XLEN-1:0] wd;
  logic [NRP*AW-1:0]   ra;
  logic [NRP*XLEN-1:0] rd;
  logic                ready;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    string       tag;
    int          lane;
    logic [31:0] exp;
  } exp_t;
  exp_t sb[$];

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .NWP(NWP)) dut (
    .clk(clk), .rst_n(rst_n), .we(we), .wa(wa), .wd(wd),
    .ra(ra), .rd(rd), .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input int lane, input logic [31:0] e);
    exp_t x;
    x.tag = tag; x.lane = lane; x.exp = e;
    sb.push_back(x);
  endtask

  // Let combinational reads settle, then compare every queued expectation
  task automatic drain();
    exp_t x;
    #1;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      chk(x.tag, rd[x.lane*XLEN +: XLEN], x.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rdaddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    ra = {a1, a0};
  endtask

  task automatic wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [31:0] d0,
                    input logic [AW-1:0] a1, input logic [31:0] d1);
    we = en; wa = {a1, a0}; wd = {d1, d0};
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
  endtask

  int n;

  initial begin
    rst_n = 1'b0; we = '0; wa = '0; wd = '0; ra = '0;
    repeat (3) tick();

    // Reset state
    chk("rst_ready", {31'b0, ready}, 32'd0);
    rdaddr(5'd5, 5'd31);
    push("rst_rd0", 0, 32'h0); push("rst_rd1", 1, 32'h0);
    drain();

    // Release; hammer x3 with writes during the walk (must be ignored)
    rst_n = 1'b1;
    wr(2'b11, 5'd3, 32'hA5A5A5A5, 5'd3, 32'hA5A5A5A5);
    rdaddr(5'd3, 5'd3);
    tick(); tick();
    chk("clr_ready", {31'b0, ready}, 32'd0);
    push("clr_rd0", 0, 32'h0); push("clr_rd1", 1, 32'h0);
    drain();
    wait_ready(n);
    chk("clear_len", n + 2, 32'd31);
    we = '0;

    // Every register reads zero after the walk, on both lanes
    for (int i = 1; i < NREG; i++) begin
      rdaddr(AW'(i), AW'(NREG - i));
      push("post_clr0", 0, 32'h0); push("post_clr1", 1, 32'h0);
      drain();
    end

    // Writes to x0 are dropped on both ports
    wr(2'b11, 5'd0, 32'hDEADBEEF, 5'd0, 32'hDEADBEEF);
    tick();
    we = '0;
    rdaddr(5'd0, 5'd0);
    push("x0_rd0", 0, 32'h0); push("x0_rd1", 1, 32'h0);
    drain();

    // Same-address collision: highest port wins
    wr(2'b11, 5'd9, 32'h11111111, 5'd9, 32'h22222222);
    rdaddr(5'd9, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
    push("coll_same0", 0, 32'h22222222); push("coll_same1", 1, 32'h22222222);
`else
    push("coll_same0", 0, 32'h0); push("coll_same1", 1, 32'h0);
`endif
    drain();
    tick();
    we = '0;
    push("coll_next0", 0, 32'h22222222); push("coll_next1", 1, 32'h22222222);
    drain();

    // Read-during-write on x10
    wr(2'b01, 5'd10, 32'hFFFFFFFF, 5'd0, 32'h0);
    rdaddr(5'd10, 5'd9);
`ifdef REGFILE_MP_BYPASS_EN
    push("rdw_same", 0, 32'hFFFFFFFF);
`else
    push("rdw_same", 0, 32'h0);
`endif
    push("rdw_other", 1, 32'h22222222);
    drain();
    tick();
    we = '0;
    push("rdw_next", 0, 32'hFFFFFFFF);
    drain();

    // Independent ports, distinct addresses; lanes cross-addressed
    wr(2'b11, 5'd7, 32'h07070707, 5'd8, 32'h08080808);
    tick();
    we = '0;
    rdaddr(5'd8, 5'd7);
    push("indep0", 0, 32'h08080808); push("indep1", 1, 32'h07070707);
    drain();

    // Disabled port must not write even with a live address
    wr(2'b10, 5'd7, 32'hBADBAD00, 5'd31, 32'h31313131);
    tick();
    we = '0;
    rdaddr(5'd7, 5'd31);
    push("we_off", 0, 32'h07070707); push("x31", 1, 32'h31313131);
    drain();

    // Store x5 before reset tests
    wr(2'b01, 5'd5, 32'h12345678, 5'd0, 32'h0);
    tick();
    we = '0;
    rdaddr(5'd5, 5'd5);
    push("x5_set", 0, 32'h12345678);
    drain();

    // Reset in READY drops ready on the next edge and zeroes reads
    rst_n = 1'b0;
    tick();
    chk("rst_rdy_drop", {31'b0, ready}, 32'd0);
    push("rst_rdy_rd", 0, 32'h0);
    drain();

    // Restart the walk, then interrupt it at count 12
    rst_n = 1'b1;
    repeat (12) tick();
    chk("mid_ready", {31'b0, ready}, 32'd0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wait_ready(n);
    chk("restart_len", n, 32'd31);

    rdaddr(5'd5, 5'd9);
    push("x5_zero", 0, 32'h0); push("x9_zero", 1, 32'h0);
    drain();
    rdaddr(5'd10, 5'd3);
    push("x10_zero", 0, 32'h0); push("x3_zero", 1, 32'h0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter XLEN, default 32, giving the data width of every register.
REQ-002 The block SHALL have parameter NREG, default 32, giving the register count (power of two, >=4); AW = log2(NREG).
REQ-003 The block SHALL have parameter NRP, default 2, giving the number of read ports (1..4).
REQ-004 The block SHALL have parameter NWP, default 2, giving the number of write ports (1..2).

Ports (name, direction, width, meaning):
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst_n  in  1  synchronous, active-low reset.
REQ-007 we  in  NWP  per-port write enable.
REQ-008 wa  in  NWP*AW  packed write addresses; port p at bits [p*AW +: AW].
REQ-009 wd  in  NWP*XLEN  packed write data.
REQ-010 ra  in  NRP*AW  packed read addresses.
REQ-011 rd  out  NRP*XLEN  packed read data, combinational from ra.
REQ-012 ready  out  1  high once the clear sequence has finished; writes are accepted only while high.

Function
REQ-013 Register 0 SHALL always read as 0, and writes to address 0 SHALL be discarded on every port.
REQ-014 The FSM SHALL have two states: CLEAR (entered on reset) and READY.
REQ-015 In CLEAR, an AW-bit counter starting at 1 SHALL write 0 to register[counter] each cycle and increment.
REQ-016 The FSM SHALL go CLEAR->READY on the edge that clears register NREG-1, so the clear sequence takes exactly NREG-1 cycles.
REQ-017 ready SHALL be 1 only in READY.
REQ-018 In CLEAR, we SHALL be ignored and every rd lane SHALL read 0.
REQ-019 READY SHALL be left only via reset.
REQ-020 In READY, each port p with we[p]=1 and wa[p]!=0 SHALL update register[wa[p]] with wd[p] at the rising edge; read-after-write latency is 1 cycle.
REQ-021 When both write ports target the same nonzero address in one cycle, port NWP-1 (the highest index) SHALL win and the other port's data is dropped.
REQ-022 Read ports SHALL be mutually independent.
REQ-023 Any number of read ports MAY address the same register.
REQ-024 Read behaviour during a same-cycle write SHALL follow REQ-030/REQ-031.

Reset
REQ-025 While rst_n=0 at a rising edge, the state SHALL be set to CLEAR, the counter to 1, and ready to 0.
REQ-026 Register contents SHALL not be reset directly; they are zeroed only by the CLEAR walk.
REQ-027 A reset asserted mid-CLEAR SHALL restart the walk at index 1.
REQ-028 A reset asserted in READY SHALL drop ready on the following edge and restart the clear sequence.
REQ-029 Outputs after reset: ready=0, and all rd lanes=0 until ready=1.

Configuration
REQ-030 With macro REGFILE_MP_BYPASS_EN defined, in READY each read lane SHALL return wd of the winning write port (per REQ-021) when that port's we=1 and its wa equals ra (nonzero) in the same cycle; otherwise it returns the stored value.
REQ-031 With REGFILE_MP_BYPASS_EN undefined, reads SHALL return the stored value only, and the new data SHALL be visible from the cycle after the write.

Verification
REQ-032 Release rst_n, count cycles -> ready rises after exactly NREG-1=31 cycles, and all registers 1..31 read 0.
REQ-033 Write 0xDEADBEEF to x0, then read x0 on all ports -> 0x00000000.
REQ-034 Same cycle: port0 writes x9=0x11111111 and port1 writes x9=0x22222222 -> next cycle x9 reads 0x22222222; with BYPASS_EN, the same-cycle read also shows 0x22222222.
REQ-035 Write x10=0xFFFFFFFF and read x10 in the same cycle -> rd=0xFFFFFFFF with BYPASS_EN; rd=previous value without it, then 0xFFFFFFFF the next cycle.
REQ-036 Write x5=0x12345678 at ready, pulse rst_n low mid-CLEAR at count 12, release -> ready reasserts 31 cycles after release and x5 reads 0.
REQ-037 In CLEAR, drive we=1 with wa=3 and wd=0xA5A5A5A5 -> ignored, and x3 reads 0 after ready.
